arith_share_arb: RTL and testbench
==================================

ARITH_SHARE_ARB -- requirements
Module: arith_share_arb

Interface
REQ-001 Parameter: NUM_REQ, default 4, number of requesters sharing one two-operand arithmetic unit (legal range 2..16).
REQ-002 Parameter: WIDTH, default 32, operand and result width in bits.
REQ-003 Port: clk  input  1  single clock; all state updates on the rising edge.
REQ-004 Port: rst  input  1  reset, synchronous and active-high.
REQ-005 Port: req_valid  input  NUM_REQ  per-requester operand-pair valid.
REQ-006 Port: req_ready  output  NUM_REQ  per-requester operand-pair accept.
REQ-007 Port: req_a_data  input  NUM_REQ*WIDTH  operand A; requester i occupies bits [i*WIDTH +: WIDTH].
REQ-008 Port: req_b_data  input  NUM_REQ*WIDTH  operand B; same packing as req_a_data.
REQ-009 Port: resp_valid  output  NUM_REQ  per-requester result valid.
REQ-010 Port: resp_ready  input  NUM_REQ  per-requester result accept.
REQ-011 Port: resp_data  output  WIDTH  shared result bus; meaningful only while some resp_valid bit is high.
REQ-012 Port: unit_a_valid / unit_a_ready / unit_a_data  output / input / output  1 / 1 / WIDTH  operand A channel to the shared unit.
REQ-013 Port: unit_b_valid / unit_b_ready / unit_b_data  output / input / output  1 / 1 / WIDTH  operand B channel to the shared unit.
REQ-014 Port: unit_result_valid / unit_result_ready / unit_result_data  input / output / input  1 / 1 / WIDTH  result channel from the shared unit.
REQ-015 Port: busy  output  1  high whenever the FSM is not IDLE.
REQ-016 Port: grant_idx  output  clog2(NUM_REQ)  index of the requester currently owning the unit; holds its last value while IDLE.

Function
REQ-017 The FSM SHALL have exactly three states: IDLE, EXEC, RESP.
REQ-018 In IDLE, if any req_valid bit is high, the winner SHALL be the first set bit scanning upward from rr_ptr with wrap-around past NUM_REQ-1 to 0.
REQ-019 In IDLE, req_ready SHALL be one-hot on the winner combinationally; all other req_ready bits SHALL be 0, and all req_ready bits SHALL be 0 in EXEC and RESP.
REQ-020 On winner handshake, the block SHALL latch A and B into internal registers, set grant_idx to the winner, clear flags a_done, b_done and r_done, and enter EXEC.
REQ-021 In EXEC: unit_a_valid = !a_done, unit_b_valid = !b_done, unit_a_data and unit_b_data driven from the latched registers, and unit_result_ready = !r_done.
REQ-022 Each of a_done, b_done and r_done SHALL set on its own channel handshake, independently; r_done SHALL capture unit_result_data into a result register.
REQ-023 EXEC SHALL go to RESP in the cycle in which all three of a_done, b_done and r_done are set, counting handshakes that occur in that same cycle.
REQ-024 In RESP: resp_valid SHALL be high for bit grant_idx only, resp_data SHALL equal the result register, and unit_*_valid and unit_result_ready SHALL be 0.
REQ-025 On resp handshake, the FSM SHALL return to IDLE and set rr_ptr = (grant_idx+1) mod NUM_REQ.
REQ-026 Latency with a combinational unit: request accepted in cycle T, EXEC in T+1, resp_valid in T+2; the next grant is possible in T+3 if resp_ready is high in T+2.
REQ-027 Outputs SHALL hold stable while resp_valid is high and resp_ready is low, for any number of cycles.
REQ-028 Requests arriving during EXEC or RESP SHALL wait; they are not lost, since req_valid is required to stay high until accepted.

Reset
REQ-029 With rst high at a clock edge, the next state SHALL be IDLE, rr_ptr = 0, grant_idx = 0, and all done flags and the result register cleared to 0, regardless of the current state.
REQ-030 During and after reset: req_ready, resp_valid, unit_a_valid, unit_b_valid, unit_result_ready and busy SHALL all be 0; an in-flight operation is discarded and no response is issued.
REQ-031 Any request handshake coinciding with rst high SHALL be ignored.

Verification
REQ-032 Bitwise-AND unit, WIDTH=32, requester 2 only, A=0xF0F0_00FF, B=0x0FF0_F00F, resp_ready=1 -> resp_valid[2] in T+2, resp_data=0x00F0_000F, busy high for cycles T+1..T+2.
REQ-033 All 4 requesters valid continuously from reset -> grants in order 0,1,2,3,0; each grant spaced 3 cycles apart.
REQ-034 Unit with unit_a_ready high only in EXEC cycle 1 and unit_b_ready high only in EXEC cycle 3 -> each operand is accepted exactly once; A valid drops after cycle 1, B valid drops after cycle 3; RESP entered after the result handshake.
REQ-035 resp_ready held low for 5 cycles in RESP -> resp_valid and resp_data stable for all 5 cycles; no req_ready asserted meanwhile.
REQ-036 rst asserted for 1 cycle in EXEC with requester 1 granted -> next cycle is IDLE, all outputs 0, no resp_valid[1]; with requester 1 still valid, the following grant goes to requester 1 (rr_ptr = 0, so scan starts at 0 and requester 0 is idle).
REQ-037 Only requester 3 valid, then only requester 0 valid -> rr_ptr wraps from 3 to 0 and requester 0 is granted immediately.

Source files
------------

// File: rtl/arith_share_arb.sv
// Round-robin arbiter sharing one two-operand arithmetic unit among NUM_REQ requesters.
// Each grant runs one operand/result exchange with the unit, then returns the result.
module arith_share_arb #(
    parameter int NUM_REQ = 4,
    parameter int WIDTH   = 32
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NUM_REQ-1:0]         req_valid,
    output logic [NUM_REQ-1:0]         req_ready,
    input  logic [NUM_REQ*WIDTH-1:0]   req_a_data,
    input  logic [NUM_REQ*WIDTH-1:0]   req_b_data,
    output logic [NUM_REQ-1:0]         resp_valid,
    input  logic [NUM_REQ-1:0]         resp_ready,
    output logic [WIDTH-1:0]           resp_data,
    output logic                       unit_a_valid,
    input  logic                       unit_a_ready,
    output logic [WIDTH-1:0]           unit_a_data,
    output logic                       unit_b_valid,
    input  logic                       unit_b_ready,
    output logic [WIDTH-1:0]           unit_b_data,
    input  logic                       unit_result_valid,
    output logic                       unit_result_ready,
    input  logic [WIDTH-1:0]           unit_result_data,
    output logic                       busy,
    output logic [$clog2(NUM_REQ)-1:0] grant_idx
);
    localparam int IW = $clog2(NUM_REQ);
    localparam int SW = IW + 1;

    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

    state_t               state;
    logic [IW-1:0]        rr_ptr;
    logic [IW-1:0]        win;
    logic [SW-1:0]        sum;
    logic [2*NUM_REQ-1:0] rot;
    logic [WIDTH-1:0]     sel_a, sel_b;
    logic [WIDTH-1:0]     a_reg, b_reg, r_reg;
    logic                 a_done, b_done, r_done;
    logic                 start, exec, a_hs, b_hs, r_hs, resp_hs;

    // Rotate so bit 0 is rr_ptr; scanning downward leaves the lowest hit in win.
    always_comb begin
        rot = {req_valid, req_valid} >> rr_ptr;
        win = rr_ptr;
        sum = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (rot[i]) begin
                sum = {1'b0, rr_ptr} + SW'(i);
                if (sum >= SW'(NUM_REQ)) sum = sum - SW'(NUM_REQ);
                win = sum[IW-1:0];
            end
        end
    end

    always_comb begin
        sel_a = '0;
        sel_b = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (win == IW'(i)) begin
                sel_a = req_a_data[i*WIDTH +: WIDTH];
                sel_b = req_b_data[i*WIDTH +: WIDTH];
            end
        end
    end

    assign start     = (state == IDLE) && (|req_valid) && !rst;
    assign req_ready = start ? (NUM_REQ'(1) << win) : '0;

    assign exec              = (state == EXEC) && !rst;
    assign unit_a_valid      = exec && !a_done;
    assign unit_b_valid      = exec && !b_done;
    assign unit_result_ready = exec && !r_done;
    assign unit_a_data       = a_reg;
    assign unit_b_data       = b_reg;

    assign a_hs = unit_a_valid && unit_a_ready;
    assign b_hs = unit_b_valid && unit_b_ready;
    assign r_hs = unit_result_valid && unit_result_ready;

    assign resp_valid = (state == RESP && !rst) ? (NUM_REQ'(1) << grant_idx) : '0;
    assign resp_data  = r_reg;
    assign resp_hs    = |(resp_valid & resp_ready);
    assign busy       = (state != IDLE) && !rst;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            rr_ptr    <= '0;
            grant_idx <= '0;
            a_done    <= 1'b0;
            b_done    <= 1'b0;
            r_done    <= 1'b0;
            a_reg     <= '0;
            b_reg     <= '0;
            r_reg     <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (start) begin
                        a_reg     <= sel_a;
                        b_reg     <= sel_b;
                        grant_idx <= win;
                        a_done    <= 1'b0;
                        b_done    <= 1'b0;
                        r_done    <= 1'b0;
                        state     <= EXEC;
                    end
                end
                EXEC: begin
                    if (a_hs) a_done <= 1'b1;
                    if (b_hs) b_done <= 1'b1;
                    if (r_hs) begin
                        r_done <= 1'b1;
                        r_reg  <= unit_result_data;
                    end
                    if ((a_done || a_hs) && (b_done || b_hs) && (r_done || r_hs))
                        state <= RESP;
                end
                RESP: begin
                    if (resp_hs) begin
                        state  <= IDLE;
                        rr_ptr <= (grant_idx == IW'(NUM_REQ - 1)) ? '0 : grant_idx + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_arith_share_arb.sv
// Self-checking bench for arith_share_arb: vector table, directed corner sequences,
// and a randomized run against a transaction-level round-robin reference model.
module tb_arith_share_arb;
    localparam int N = 4;
    localparam int W = 32;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic [N-1:0]   req_valid, req_ready, resp_valid, resp_ready;
    logic [N*W-1:0] req_a_data, req_b_data;
    logic [W-1:0]   resp_data, unit_a_data, unit_b_data, unit_result_data;
    logic           unit_a_valid, unit_a_ready, unit_b_valid, unit_b_ready;
    logic           unit_result_valid, unit_result_ready, busy;
    logic [1:0]     grant_idx;

    arith_share_arb #(.NUM_REQ(N), .WIDTH(W)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_a_data(req_a_data), .req_b_data(req_b_data),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_data(resp_data),
        .unit_a_valid(unit_a_valid), .unit_a_ready(unit_a_ready), .unit_a_data(unit_a_data),
        .unit_b_valid(unit_b_valid), .unit_b_ready(unit_b_ready), .unit_b_data(unit_b_data),
        .unit_result_valid(unit_result_valid), .unit_result_ready(unit_result_ready),
        .unit_result_data(unit_result_data),
        .busy(busy), .grant_idx(grant_idx)
    );

    // Shared unit: combinational AND or SUB, result offered once both operands are in.
    logic         ha, hb, ur_en, mode_sub;
    logic [W-1:0] ra, rb, ea, eb;
    int           na = 0;
    int           nb = 0;

    always_comb begin
        ea = ha ? ra : unit_a_data;
        eb = hb ? rb : unit_b_data;
        unit_result_valid = ur_en && (ha || (unit_a_valid && unit_a_ready))
                                  && (hb || (unit_b_valid && unit_b_ready));
        unit_result_data = mode_sub ? ea - eb : ea & eb;
    end

    always_ff @(posedge clk) begin
        if (rst || (unit_result_valid && unit_result_ready)) begin
            ha <= 1'b0;
            hb <= 1'b0;
        end else begin
            if (unit_a_valid && unit_a_ready) begin
                ha <= 1'b1;
                ra <= unit_a_data;
            end
            if (unit_b_valid && unit_b_ready) begin
                hb <= 1'b1;
                rb <= unit_b_data;
            end
        end
        if (unit_a_valid && unit_a_ready) na <= na + 1;
        if (unit_b_valid && unit_b_ready) nb <= nb + 1;
    end

    int checks = 0;
    int errors = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic set_req(input int i, input logic [W-1:0] a, input logic [W-1:0] b);
        req_a_data[i*W +: W] = a;
        req_b_data[i*W +: W] = b;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        req_valid = '0;
        resp_ready = '1;
        unit_a_ready = 1'b1;
        unit_b_ready = 1'b1;
        ur_en = 1'b1;
        mode_sub = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    function automatic int pick(input logic [N-1:0] v, input int p);
        for (int k = 0; k < N; k++) begin
            int j;
            j = (p + k) % N;
            if (v[j[1:0]]) return j;
        end
        return -1;
    endfunction

    typedef struct {
        int         idx;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic       sub;
        logic [W-1:0] exp;
    } vec_t;

    vec_t vt[5];

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "time limit");
    end

    initial begin
        logic [N-1:0] drop;
        logic [W-1:0] qa[N], qb[N];
        logic [W-1:0] exp_d;
        logic         bm;
        int rr_m, w, wait_c, done_ops, na0, nb0;

        vt[0] = '{2, 32'hF0F0_00FF, 32'h0FF0_F00F, 1'b0, 32'h00F0_000F};
        vt[1] = '{0, 32'hFFFF_FFFF, 32'h1234_5678, 1'b0, 32'h1234_5678};
        vt[2] = '{3, 32'h0000_0000, 32'h0000_0001, 1'b1, 32'hFFFF_FFFF};
        vt[3] = '{1, 32'h0000_0010, 32'h0000_0003, 1'b1, 32'h0000_000D};
        vt[4] = '{3, 32'h8000_0000, 32'h0000_0001, 1'b1, 32'h7FFF_FFFF};

        req_a_data = '0;
        req_b_data = '0;

        // Reset state, with requests present during reset
        do_reset();
        rst = 1'b1;
        req_valid = 4'hF;
        @(negedge clk);
        @(negedge clk);
        #1;
        chk("rst_ready", req_ready, 0);
        chk("rst_outs", {resp_valid, unit_a_valid, unit_b_valid, unit_result_ready, busy}, 0);
        chk("rst_gidx", grant_idx, 0);
        @(negedge clk);
        rst = 1'b0;
        req_valid = '0;
        #1;
        chk("rst_ignored", busy, 0);

        // Vector table: single requester, combinational unit, T/T+1/T+2/T+3
        foreach (vt[k]) begin
            @(negedge clk);
            mode_sub = vt[k].sub;
            set_req(vt[k].idx, vt[k].a, vt[k].b);
            req_valid = '0;
            req_valid[vt[k].idx] = 1'b1;
            #1;
            chk("v_ready", req_ready, 4'b1 << vt[k].idx);
            @(negedge clk);
            req_valid = '0;
            #1;
            chk("v_exec", {busy, grant_idx}, {1'b1, 2'(vt[k].idx)});
            chk("v_opnd", {unit_a_data, unit_b_data}, {vt[k].a, vt[k].b});
            @(negedge clk);
            #1;
            chk("v_resp", {busy, resp_valid}, {1'b1, 4'b1 << vt[k].idx});
            chk("v_data", resp_data, vt[k].exp);
            @(negedge clk);
            #1;
            chk("v_idle", {busy, resp_valid}, 0);
        end

        // All requesters continuously valid: 0,1,2,3,0 spaced 3 cycles
        do_reset();
        for (int i = 0; i < N; i++) set_req(i, $urandom, $urandom);
        req_valid = 4'hF;
        for (int c = 0; c < 13; c++) begin
            if (c > 0) @(negedge clk);
            #1;
            chk("rr_seq", req_ready, (c % 3 == 0) ? (4'b1 << ((c / 3) % 4)) : 4'b0);
        end

        // Staggered operand readiness
        do_reset();
        set_req(1, 32'h1234_5678, 32'h0F0F_0F0F);
        unit_a_ready = 1'b0;
        unit_b_ready = 1'b0;
        na0 = na;
        nb0 = nb;
        req_valid = 4'b0010;
        #1;
        chk("h_grant", req_ready, 4'b0010);
        @(negedge clk);
        req_valid = '0;
        unit_a_ready = 1'b1;
        #1;
        chk("h_c1", {unit_a_valid, unit_b_valid, unit_result_ready}, 3'b111);
        @(negedge clk);
        unit_a_ready = 1'b0;
        #1;
        chk("h_c2", {unit_a_valid, unit_b_valid, unit_result_ready}, 3'b011);
        @(negedge clk);
        unit_b_ready = 1'b1;
        #1;
        chk("h_c3", {unit_a_valid, unit_b_valid, unit_result_ready, resp_valid}, 7'b0110000);
        @(negedge clk);
        #1;
        chk("h_resp", resp_valid, 4'b0010);
        chk("h_data", resp_data, 32'h0204_0608);
        chk("h_uidle", {unit_a_valid, unit_b_valid, unit_result_ready}, 0);
        chk("h_cnt", {na - na0, nb - nb0}, {32'd1, 32'd1});

        // Response back-pressure for 5 cycles
        do_reset();
        set_req(0, 32'hAAAA_5555, 32'hFFFF_0000);
        set_req(3, 32'h1, 32'h1);
        req_valid = 4'b0001;
        resp_ready = '0;
        #1;
        chk("s_grant", req_ready, 4'b0001);
        @(negedge clk);
        req_valid = 4'b1000;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            #1;
            chk("s_valid", resp_valid, 4'b0001);
            chk("s_data", resp_data, 32'hAAAA_0000);
            chk("s_noready", req_ready, 0);
        end
        @(negedge clk);
        resp_ready = '1;
        #1;
        chk("s_hs", resp_valid, 4'b0001);
        @(negedge clk);
        req_valid = 4'b1001;
        #1;
        chk("s_next", req_ready, 4'b1000);

        // Reset during EXEC discards the operation
        do_reset();
        set_req(1, 32'h5, 32'h3);
        req_valid = 4'b0010;
        #1;
        chk("x_grant", req_ready, 4'b0010);
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("x_rst", {req_ready, resp_valid, unit_a_valid, unit_b_valid, unit_result_ready, busy}, 0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("x_idle", {busy, resp_valid, grant_idx}, 0);
        chk("x_regrant", req_ready, 4'b0010);
        @(negedge clk);
        req_valid = '0;
        #1;
        chk("x_exec", {busy, grant_idx, resp_valid}, {1'b1, 2'd1, 4'b0});
        @(negedge clk);
        #1;
        chk("x_resp", {resp_valid, resp_data}, {4'b0010, 32'h1});

        // Pointer wrap from 3 back to 0
        do_reset();
        set_req(3, 32'h7, 32'h7);
        req_valid = 4'b1000;
        #1;
        chk("w_grant3", req_ready, 4'b1000);
        @(negedge clk);
        req_valid = '0;
        @(negedge clk);
        #1;
        chk("w_resp3", resp_valid, 4'b1000);
        @(negedge clk);
        set_req(0, 32'h9, 32'h3);
        req_valid = 4'b0001;
        #1;
        chk("w_wrap", req_ready, 4'b0001);
        @(negedge clk);
        req_valid = '0;
        @(negedge clk);

        // Randomized traffic against the round-robin transaction model
        do_reset();
        mode_sub = 1'b1;
        drop = '0;
        bm = 1'b0;
        rr_m = 0;
        w = -1;
        wait_c = 0;
        done_ops = 0;
        exp_d = '0;
        na0 = na;
        nb0 = nb;
        for (int c = 0; c < 3000; c++) begin
            if (c > 0) @(negedge clk);
            req_valid = req_valid & ~drop;
            drop = '0;
            for (int i = 0; i < N; i++) begin
                if (!req_valid[i] && $urandom_range(3) == 0) begin
                    qa[i] = $urandom;
                    qb[i] = $urandom;
                    set_req(i, qa[i], qb[i]);
                    req_valid[i] = 1'b1;
                end
            end
            unit_a_ready = 1'($urandom_range(1));
            unit_b_ready = 1'($urandom_range(1));
            ur_en = ($urandom_range(3) != 0);
            resp_ready = 4'($urandom);
            #1;
            chk("r_busy", busy, bm);
            if (!bm) begin
                w = pick(req_valid, rr_m);
                chk("r_ready", req_ready, (w < 0) ? 4'b0 : (4'b1 << w));
                chk("r_noresp", resp_valid, 0);
                if (w >= 0) begin
                    bm = 1'b1;
                    drop[w] = 1'b1;
                    exp_d = qa[w] - qb[w];
                    wait_c = 0;
                end
            end else begin
                chk("r_hold", req_ready, 0);
                wait_c++;
                if (resp_valid != 0) begin
                    chk("r_resp", resp_valid, 4'b1 << w);
                    chk("r_data", resp_data, exp_d);
                    if (resp_ready[w]) begin
                        bm = 1'b0;
                        rr_m = (w + 1) % N;
                        done_ops++;
                    end
                end else if (wait_c > 100) begin
                    chk("r_timeout", resp_valid, 4'b1 << w);
                    break;
                end
            end
        end
        @(negedge clk);
        req_valid = '0;
        unit_a_ready = 1'b1;
        unit_b_ready = 1'b1;
        ur_en = 1'b1;
        resp_ready = '1;
        for (int c = 0; c < 6; c++) begin
            #1;
            if (bm && resp_valid != 0) begin
                chk("r_dresp", {resp_valid, resp_data}, {4'b1 << w, exp_d});
                bm = 1'b0;
                done_ops++;
            end
            @(negedge clk);
        end
        chk("r_drained", {bm, busy}, 0);
        chk("r_cnt", {na - na0, nb - nb0}, {32'(done_ops), 32'(done_ops)});
        chk("r_progress", done_ops > 100, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
